// File: rtl/div_radix2.sv
// div_radix2: multi-cycle radix-2 restoring divider (DIV/DIVU), one quotient bit per clock.
// Ports: clk, rst (async, active-low), signed_div_i, opdata1_i (dividend), opdata2_i (divisor),
//        start_i, annul_i (abort), result_o {rem, quot}, ready_o (one-cycle pulse), busy_o.
// Optional: define DIV_EARLY_OUT_EN to finish at once when |divisor| > |dividend|.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] rem, quot, dvs, a_mag, b_mag, rem_nxt, quot_nxt, q_fix, r_fix;
  logic [WIDTH:0] trial;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, qbit, last, early, go;
  assign a_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign b_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
  assign early = b_mag > a_mag;
`else
  assign early = 1'b0;
`endif
  // Shift the next dividend bit into the partial remainder and keep the
  // subtraction only when it does not borrow.
  assign trial    = {rem, quot[WIDTH-1]} - {1'b0, dvs};
  assign qbit     = ~trial[WIDTH];
  assign rem_nxt  = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quot[WIDTH-1]};
  assign quot_nxt = {quot[WIDTH-2:0], qbit};
  assign q_fix    = neg_q ? -quot_nxt : quot_nxt;
  assign r_fix    = neg_r ? -rem_nxt : rem_nxt;
  assign last     = cnt == CW'(WIDTH - 1);
  assign go       = start_i && !annul_i;
  assign ready_o  = state == DONE && !annul_i;
  assign busy_o   = state == BUSY;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = go ? ((opdata2_i == '0 || early) ? DONE : BUSY) : IDLE;
    else if (state == BUSY) state_nxt = annul_i ? IDLE : (last ? DONE : BUSY);
    else state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        neg_r <= signed_div_i && opdata1_i[WIDTH-1];
        dvs   <= b_mag;
        rem   <= '0;
        quot  <= a_mag;
        cnt   <= '0;
        if (opdata2_i == '0) result_o <= '0;
        else if (early) result_o <= {opdata1_i, {WIDTH{1'b0}}};
      end else if (state == BUSY && !annul_i) begin
        rem  <= rem_nxt;
        quot <= quot_nxt;
        cnt  <= cnt + 1'b1;
        if (last) result_o <= {r_fix, q_fix};
      end
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: table-driven and scoreboarded bench for div_radix2.
module tb_div_radix2;
  logic clk = 0, rst = 0, signed_div_i = 0, start_i = 0, annul_i = 0;
  logic [31:0] opdata1_i = 0, opdata2_i = 0;
  logic [63:0] result_o;
  logic ready_o, busy_o;
  int tests = 0, fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 0;

  typedef struct {logic s; logic [31:0] a; logic [31:0] b; logic [63:0] e;} vec_t;
  vec_t vecs[12];

  div_radix2 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm, q, r;
    if (b == 0) return 64'd0;
    am = (s && a[31]) ? -a : a;
    bm = (s && b[31]) ? -b : b;
    q = am / bm;
    r = am % bm;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  function automatic int lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm;
    am = (s && a[31]) ? -a : a;
    bm = (s && b[31]) ? -b : b;
    if (b == 0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (bm > am) return 1;
`endif
    return (am == bm) ? 33 : 33;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_o && n < 80);
  endtask

  task automatic pop_chk(input string name);
    logic [63:0] e;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
    chk({name, " result"}, result_o, e);
    last_res = e;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input string name);
    int n, bz;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1;
    exp_q.push_back(e);
    n = 0; bz = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy_o) bz++;
      if (n == 3) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
      end
    end while (!ready_o && n < 80);
    chk({name, " latency"}, 64'(n), 64'(lat(s, a, b)));
    chk({name, " busy cycles"}, 64'(bz), 64'(lat(s, a, b) - 1));
    pop_chk(name);
    @(negedge clk);
    start_i = 0;
    @(posedge clk); #1;
    chk({name, " ready pulse"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    int n;
    logic s;
    logic [31:0] a, b;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD}};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000}};
    vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0}};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          64'd0};
    vecs[6]  = '{1'b0, 32'hDEADBEEF,   32'd0,          64'd0};
    vecs[7]  = '{1'b0, 32'd5,          32'd9,          {32'd5, 32'd0}};
    vecs[8]  = '{1'b1, 32'hFFFFFFFB,   32'd9,          {32'hFFFFFFFB, 32'd0}};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF}};
    vecs[10] = '{1'b1, 32'd9,          32'd3,          {32'd0, 32'd3}};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1}};
    #2;
    chk("reset result", result_o, 64'd0);
    chk("reset ready/busy", {62'd0, ready_o, busy_o}, 64'd0);
    @(negedge clk); rst = 1;
    for (int i = 0; i < 12; i++) run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom >> $urandom_range(0, 31); s = 1'($urandom_range(0, 1));
      run_div(s, a, b, model(s, a, b), $sformatf("rnd%0d", i));
    end
    // back-to-back: start held through DONE with new operands
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 100; opdata2_i = 7; start_i = 1;
    exp_q.push_back({32'd2, 32'd14});
    wait_ready(n);
    pop_chk("b2b first");
    signed_div_i = 1; opdata1_i = 9; opdata2_i = 3;
    exp_q.push_back({32'd0, 32'd3});
    wait_ready(n);
    chk("b2b second latency", 64'(n), 64'd34);
    pop_chk("b2b second");
    @(negedge clk); start_i = 0;
    // annul at iteration 10
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 1000; opdata2_i = 3; start_i = 1;
    for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
    chk("annul busy before", {63'd0, busy_o}, 64'd1);
    annul_i = 1; start_i = 0;
    @(posedge clk); #1;
    annul_i = 0;
    chk("annul busy after", {63'd0, busy_o}, 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (ready_o) n++; end
    chk("annul no ready", 64'(n), 64'd0);
    chk("annul result held", result_o, last_res);
    // annul during DONE suppresses ready_o
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 50; opdata2_i = 0; start_i = 1;
    @(posedge clk); #1;
    chk("done ready", {63'd0, ready_o}, 64'd1);
    annul_i = 1; start_i = 0;
    #1;
    chk("done annul ready", {63'd0, ready_o}, 64'd0);
    chk("done annul result", result_o, 64'd0);
    @(posedge clk); #1;
    annul_i = 0;
    chk("done annul idle", {62'd0, ready_o, busy_o}, 64'd0);
    // async reset at iteration 20
    run_div(1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, "pre-reset");
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 1234; opdata2_i = 7; start_i = 1;
    for (int i = 0; i < 21; i++) begin @(posedge clk); #1; end
    rst = 0;
    #1;
    chk("async reset result", result_o, 64'd0);
    chk("async reset flags", {62'd0, ready_o, busy_o}, 64'd0);
    @(negedge clk); rst = 1; start_i = 0;
    @(posedge clk); #1;
    chk("post reset idle", {62'd0, ready_o, busy_o}, 64'd0);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7), "post-reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
